// File: rtl/keypad_calc.sv
// Keypad-driven decimal calculator: two operands of up to DIGITS digits,
// add / subtract / multiply, with a sequential shift-add multiplier.
module keypad_calc #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned OW     = 7
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    output logic [OW-1:0]               opnd_a,
    output logic [OW-1:0]               opnd_b,
    output logic [$clog2(DIGITS+1)-1:0] digit_cnt,
    output logic [2*OW-1:0]             result,
    output logic                        neg,
    output logic                        result_valid,
    output logic                        busy
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned MW = (OW > 1) ? $clog2(OW) : 1;

    if (2**OW <= 10**DIGITS - 1) begin : g_ow_too_small
        $error("keypad_calc: OW too narrow to hold DIGITS decimal digits");
    end

    typedef enum logic [1:0] {ENTER_A, ENTER_B, COMPUTE, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL}          op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_key;
    logic [OW-1:0]       a_q, b_q;
    logic [CW-1:0]       cnt_q;
    logic [2*OW-1:0]     res_q;
    logic                neg_q;
    logic                rv_q;
    logic [2*OW-1:0]     acc_q, mcand_q;
    logic [OW-1:0]       mplier_q;
    logic [MW-1:0]       mstep_q;

    logic                key_digit, key_op, key_eq, key_clr;
    logic                can_digit, mul_last;
    logic [OW-1:0]       digit_ext, diff;
    logic [2*OW-1:0]     sum, mul_sum;

    always_comb begin
        key_digit = key_valid && (key_code <= 4'd9);
        key_op    = key_valid && (key_code inside {4'hA, 4'hB, 4'hC});
        key_eq    = key_valid && (key_code == 4'hE);
        key_clr   = key_valid && (key_code == 4'hF);
        case (key_code)
            4'hB:    op_key = OP_SUB;
            4'hC:    op_key = OP_MUL;
            default: op_key = OP_ADD;
        endcase
        digit_ext = OW'(key_code);
        can_digit = (cnt_q < CW'(DIGITS));
        mul_last  = (mstep_q == MW'(OW - 1));
        diff      = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
        sum       = (2*OW)'(a_q) + (2*OW)'(b_q);
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ENTER_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (key_clr) begin
            state_d = ENTER_A;
        end else begin
            case (state_q)
                ENTER_A: if (key_op) state_d = ENTER_B;
                ENTER_B: if (key_eq) state_d = COMPUTE;
                COMPUTE: if (op_q != OP_MUL || mul_last) state_d = DONE;
                DONE:    if (key_digit) state_d = ENTER_A;
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == COMPUTE);
        result_valid = rv_q;
    end

    // Multiplier consumes one bit of b per cycle; result only loads on the final step.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
            rv_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mstep_q  <= '0;
        end else begin
            rv_q <= 1'b0;
            if (key_clr) begin
                op_q  <= OP_ADD;
                a_q   <= '0;
                b_q   <= '0;
                cnt_q <= '0;
                res_q <= '0;
                neg_q <= 1'b0;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (key_digit && can_digit) begin
                            a_q   <= a_q * OW'(10) + digit_ext;
                            cnt_q <= cnt_q + CW'(1);
                        end else if (key_op) begin
                            op_q  <= op_key;
                            b_q   <= '0;
                            cnt_q <= '0;
                        end
                    end
                    ENTER_B: begin
                        if (key_digit && can_digit) begin
                            b_q   <= b_q * OW'(10) + digit_ext;
                            cnt_q <= cnt_q + CW'(1);
                        end else if (key_op) begin
                            op_q <= op_key;
                        end else if (key_eq) begin
                            acc_q    <= '0;
                            mcand_q  <= (2*OW)'(a_q);
                            mplier_q <= b_q;
                            mstep_q  <= '0;
                        end
                    end
                    COMPUTE: begin
                        case (op_q)
                            OP_MUL: begin
                                acc_q    <= mul_sum;
                                mcand_q  <= mcand_q << 1;
                                mplier_q <= mplier_q >> 1;
                                mstep_q  <= mstep_q + MW'(1);
                                if (mul_last) begin
                                    res_q <= mul_sum;
                                    neg_q <= 1'b0;
                                    rv_q  <= 1'b1;
                                end
                            end
                            OP_SUB: begin
                                res_q <= (2*OW)'(diff);
                                neg_q <= (a_q < b_q);
                                rv_q  <= 1'b1;
                            end
                            default: begin
                                res_q <= sum;
                                neg_q <= 1'b0;
                                rv_q  <= 1'b1;
                            end
                        endcase
                    end
                    DONE: begin
                        if (key_digit) begin
                            a_q   <= digit_ext;
                            b_q   <= '0;
                            cnt_q <= CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign opnd_a    = a_q;
    assign opnd_b    = b_q;
    assign digit_cnt = cnt_q;
    assign result    = res_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_keypad_calc.sv
// Scoreboard bench for keypad_calc: expected results are queued when E is
// pressed and matched against each result_valid pulse.
module tb_keypad_calc;

    localparam int DIGITS = 2;
    localparam int OW     = 7;

    logic                        clk = 1'b0;
    logic                        clr_n = 1'b0;
    logic                        key_valid = 1'b0;
    logic [3:0]                  key_code = 4'd0;
    logic [OW-1:0]               opnd_a, opnd_b;
    logic [$clog2(DIGITS+1)-1:0] digit_cnt;
    logic [2*OW-1:0]             result;
    logic                        neg, result_valid, busy;

    keypad_calc #(.DIGITS(DIGITS), .OW(OW)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .opnd_a       (opnd_a),
        .opnd_b       (opnd_b),
        .digit_cnt    (digit_cnt),
        .result       (result),
        .neg          (neg),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*OW-1:0] res;
        logic            neg;
        int              lat;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic keys(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            press((c >= 8'h41) ? 4'(c - 8'h37) : 4'(c - 8'h30));
        end
    endtask

    task automatic expect_res(input int r, input logic n, input int lat);
        sb.push_back('{res: (2*OW)'(r), neg: n, lat: lat, cyc: cyc});
    endtask

    task automatic wait_done();
        busy_n = 0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
            if (busy) busy_n++;
        end
        check("done_in_time", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic outs(input string t, input int a, input int b, input int c,
                        input int r, input int n);
        check({t, ".opnd_a"},    64'(opnd_a),       64'(a));
        check({t, ".opnd_b"},    64'(opnd_b),       64'(b));
        check({t, ".digit_cnt"}, 64'(digit_cnt),    64'(c));
        check({t, ".result"},    64'(result),       64'(r));
        check({t, ".neg"},       64'(neg),          64'(n));
        check({t, ".rv"},        64'(result_valid), 64'd0);
        check({t, ".busy"},      64'(busy),         64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (result_valid) begin
            if (sb.size() == 0) begin
                check("rv_spurious", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result",  64'(result), 64'(e.res));
                check("neg",     64'(neg),    64'(e.neg));
                check("latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
        end
    end

    initial begin
        #3;
        outs("reset", 0, 0, 0, 0, 0);
        #10 clr_n = 1'b1;

        keys("1");
        check("first_key", 64'(opnd_a), 64'd1);
        keys("23");
        outs("third_digit", 12, 0, 2, 0, 0);
        keys("B");
        outs("to_b", 12, 0, 0, 0, 0);
        keys("45E");
        expect_res(33, 1'b1, 1);
        wait_done();
        check("busy_sub", 64'(busy_n), 64'd1);

        keys("5");
        outs("done_digit", 5, 0, 1, 33, 1);

        keys("F");
        outs("clear", 0, 0, 0, 0, 0);
        keys("99C99E");
        expect_res(9801, 1'b0, OW);
        wait_done();
        check("busy_mul", 64'(busy_n), 64'(OW));

        keys("F7E");
        outs("eq_in_a", 7, 0, 1, 0, 0);
        keys("AC5D");
        outs("key_d", 7, 5, 1, 0, 0);
        keys("E");
        expect_res(35, 1'b0, OW);
        wait_done();

        keys("6A2C");
        outs("b_held", 6, 2, 1, 35, 0);
        keys("E");
        expect_res(12, 1'b0, OW);
        wait_done();

        keys("50B8E");
        expect_res(42, 1'b0, 1);
        wait_done();
        keys("99A99E");
        expect_res(198, 1'b0, 1);
        wait_done();
        check("busy_add", 64'(busy_n), 64'd1);

        keys("8C9E");
        @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        keys("F");
        outs("abort", 0, 0, 0, 0, 0);
        repeat (12) @(negedge clk);

        keys("6C7E");
        repeat (2) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        outs("async_clr", 0, 0, 0, 0, 0);
        #4 clr_n = 1'b1;
        keys("3");
        check("post_clr_key", 64'(opnd_a), 64'd3);
        keys("A4E");
        expect_res(7, 1'b0, 1);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
